// File: rtl/decode_stage_if.sv
// Decode-stage bus: decode inputs, writeback port, flush, and the decode-to-execute register outputs.
interface decode_stage_if #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]             InstrD;
  logic [DATA_WIDTH-1:0]             PCD;
  logic [DATA_WIDTH-1:0]             PCPlus4D;
  logic                              RegWriteW;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW;
  logic [DATA_WIDTH-1:0]             ResultW;
  logic                              FlushE;

  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D;

  logic                              RegWriteE;
  logic                              MemWriteE;
  logic                              JumpE;
  logic                              BranchE;
  logic                              ALUSrcE;
  logic [1:0]                        ResultSrcE;
  logic [3:0]                        ALUControlE;
  logic [2:0]                        Funct3E;
  logic [DATA_WIDTH-1:0]             RD1E;
  logic [DATA_WIDTH-1:0]             RD2E;
  logic [DATA_WIDTH-1:0]             PCE;
  logic [DATA_WIDTH-1:0]             ExtImmE;
  logic [DATA_WIDTH-1:0]             PCPlus4E;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E;
  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE;

  modport master (
    output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    input  Rs1D, Rs2D,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, Funct3E,
    input  RD1E, RD2E, PCE, ExtImmE, PCPlus4E, Rs1E, Rs2E, RdE
  );

  modport slave (
    input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
    output Rs1D, Rs2D,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, Funct3E,
    output RD1E, RD2E, PCE, ExtImmE, PCPlus4E, Rs1E, Rs2E, RdE
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, control/immediate decode and the D->E pipeline register.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data onto the read ports.
module decode_stage #(
  parameter int DATA_WIDTH             = 32,
  parameter int REG_FILE_ADDRESS_WIDTH = 5
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave dec_if
);

  localparam int NREGS = 1 << REG_FILE_ADDRESS_WIDTH;
  localparam int AW    = REG_FILE_ADDRESS_WIDTH;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_PASSB = 4'b1010;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Immediate builders: the RV32I layout is assembled at 32 bits, then sign-extended to the datapath.
  function automatic logic [DATA_WIDTH-1:0] sext32(input logic signed [31:0] v);
    return DATA_WIDTH'(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_i(input logic [31:0] ins);
    return sext32({{20{ins[31]}}, ins[31:20]});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_s(input logic [31:0] ins);
    return sext32({{20{ins[31]}}, ins[31:25], ins[11:7]});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_b(input logic [31:0] ins);
    return sext32({{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_j(input logic [31:0] ins);
    return sext32({{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] imm_u(input logic [31:0] ins);
    return sext32({ins[31:12], 12'b0});
  endfunction

  // SUB exists only for register-register ops; SRA is selected by funct7[5] for both forms.
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5, input logic is_r);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0]   instr;
  logic [6:0]    opcode;
  logic [AW-1:0] rs1;
  logic [AW-1:0] rs2;

  assign instr  = dec_if.InstrD[31:0];
  assign opcode = instr[6:0];
  assign rs1    = AW'(instr[19:15]);
  assign rs2    = AW'(instr[24:20]);

  assign dec_if.Rs1D = rs1;
  assign dec_if.Rs2D = rs2;

  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  assign rf_we = dec_if.RegWriteW && (dec_if.RdW != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[dec_if.RdW] <= dec_if.ResultW;
    end
  end

  // x0 is hard-wired; rf_q[0] is never written but is masked anyway.
  always_comb begin
    rd1 = (rs1 == '0) ? '0 : rf_q[rs1];
    rd2 = (rs2 == '0) ? '0 : rf_q[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (rf_we && (dec_if.RdW == rs1)) rd1 = dec_if.ResultW;
    if (rf_we && (dec_if.RdW == rs2)) rd2 = dec_if.ResultW;
`endif
  end

  logic                  reg_write_d, mem_write_d, jump_d, branch_d, alu_src_d;
  logic [1:0]            result_src_d;
  logic [3:0]            alu_ctrl_d;
  logic [DATA_WIDTH-1:0] imm_d;

  // Unrecognised opcodes fall through the defaults and become a bubble.
  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    jump_d       = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    result_src_d = RES_ALU;
    alu_ctrl_d   = ALU_ADD;
    imm_d        = '0;
    case (opcode)
      OP_R: begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = alu_op(instr[14:12], instr[30], 1'b1);
      end
      OP_I: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = alu_op(instr[14:12], instr[30], 1'b0);
        imm_d       = imm_i(instr);
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = RES_MEM;
        imm_d        = imm_i(instr);
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_s(instr);
      end
      OP_BR: begin
        branch_d   = 1'b1;
        alu_ctrl_d = ALU_SUB;
        imm_d      = imm_b(instr);
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        result_src_d = RES_PC4;
        imm_d        = imm_j(instr);
      end
      OP_JALR: begin
        reg_write_d  = 1'b1;
        jump_d       = 1'b1;
        alu_src_d    = 1'b1;
        result_src_d = RES_PC4;
        imm_d        = imm_i(instr);
      end
      OP_LUI: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        alu_ctrl_d  = ALU_PASSB;
        imm_d       = imm_u(instr);
      end
      OP_AUIPC: begin
        reg_write_d = 1'b1;
        alu_src_d   = 1'b1;
        imm_d       = imm_u(instr);
      end
      default: ;
    endcase
  end

  logic                  reg_write_q, mem_write_q, jump_q, branch_q, alu_src_q;
  logic [1:0]            result_src_q;
  logic [3:0]            alu_ctrl_q;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] rd1_q, rd2_q, pc_q, imm_q, pc4_q;
  logic [AW-1:0]         rs1_q, rs2_q, rd_q;

  // ---- D -> E pipeline register: reset and flush both load an all-zero bubble ----
  always_ff @(posedge clk) begin
    if (!rst_n || dec_if.FlushE) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      jump_q       <= 1'b0;
      branch_q     <= 1'b0;
      alu_src_q    <= 1'b0;
      result_src_q <= '0;
      alu_ctrl_q   <= '0;
      funct3_q     <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      pc4_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      jump_q       <= jump_d;
      branch_q     <= branch_d;
      alu_src_q    <= alu_src_d;
      result_src_q <= result_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      funct3_q     <= instr[14:12];
      rd1_q        <= rd1;
      rd2_q        <= rd2;
      pc_q         <= dec_if.PCD;
      imm_q        <= imm_d;
      pc4_q        <= dec_if.PCPlus4D;
      rs1_q        <= rs1;
      rs2_q        <= rs2;
      rd_q         <= AW'(instr[11:7]);
    end
  end

  assign dec_if.RegWriteE   = reg_write_q;
  assign dec_if.MemWriteE   = mem_write_q;
  assign dec_if.JumpE       = jump_q;
  assign dec_if.BranchE     = branch_q;
  assign dec_if.ALUSrcE     = alu_src_q;
  assign dec_if.ResultSrcE  = result_src_q;
  assign dec_if.ALUControlE = alu_ctrl_q;
  assign dec_if.Funct3E     = funct3_q;
  assign dec_if.RD1E        = rd1_q;
  assign dec_if.RD2E        = rd2_q;
  assign dec_if.PCE         = pc_q;
  assign dec_if.ExtImmE     = imm_q;
  assign dec_if.PCPlus4E    = pc4_q;
  assign dec_if.Rs1E        = rs1_q;
  assign dec_if.Rs2E        = rs2_q;
  assign dec_if.RdE         = rd_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench for decode_stage against a table-driven RV32I decode model.
module tb_decode_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5)) dif ();

  decode_stage #(.DATA_WIDTH(32), .REG_FILE_ADDRESS_WIDTH(5)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dec_if (dif.slave)
  );

  typedef struct {
    logic        rw, mw, j, b, as;
    logic [1:0]  rsrc;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, pc, imm, pc4;
    logic [4:0]  rs1, rs2, rd;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] mrf [32];

  // Kind order: R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, other
  logic [6:0] op_t   [9]  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
  int         rw_t   [10] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  int         mw_t   [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int         jmp_t  [10] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
  int         br_t   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
  int         as_t   [10] = '{0, 1, 1, 1, 0, 0, 1, 1, 1, 0};
  int         rsrc_t [10] = '{0, 0, 1, 0, 0, 2, 2, 0, 0, 0};
  int         alu_t  [10] = '{-1, -1, 0, 0, 1, 0, 0, 10, 0, 0};
  int         immk_t [10] = '{0, 1, 1, 2, 3, 4, 1, 5, 5, 0};
  int         f3alu  [8]  = '{0, 5, 8, 9, 4, 6, 3, 2};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic rw,
                                          input logic [4:0] wrd, input logic [31:0] res);
    if (a == 0) return 32'h0;
`ifdef DECODE_WB_BYPASS_EN
    if (rw && wrd == a) return res;
`endif
    return mrf[a];
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic rw,
                                 input logic [4:0] wrd, input logic [31:0] res);
    exp_t e;
    int k = 9;
    int si;
    int imm;
    for (int i = 0; i < 9; i++) if (ins[6:0] == op_t[i]) k = i;
    si = ins;
    case (immk_t[k])
      1: imm = si >>> 20;
      2: imm = (si >>> 25) * 32 + int'(ins[11:7]);
      3: imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      4: imm = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      5: imm = si & 32'hFFFFF000;
      default: imm = 0;
    endcase
    e.rw   = rw_t[k] != 0;
    e.mw   = mw_t[k] != 0;
    e.j    = jmp_t[k] != 0;
    e.b    = br_t[k] != 0;
    e.as   = as_t[k] != 0;
    e.rsrc = 2'(rsrc_t[k]);
    if (alu_t[k] >= 0) e.alu = 4'(alu_t[k]);
    else begin
      e.alu = 4'(f3alu[ins[14:12]]);
      if (ins[14:12] == 3'd5 && ins[30]) e.alu = 4'd7;
      if (k == 0 && ins[14:12] == 3'd0 && ins[30]) e.alu = 4'd1;
    end
    e.f3  = ins[14:12];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.rd1 = rf_read(e.rs1, rw, wrd, res);
    e.rd2 = rf_read(e.rs2, rw, wrd, res);
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    e.imm = imm;
    return e;
  endfunction

  task automatic compare_all(input exp_t e);
    chk("RegWriteE",   32'(dif.RegWriteE),   32'(e.rw));
    chk("MemWriteE",   32'(dif.MemWriteE),   32'(e.mw));
    chk("JumpE",       32'(dif.JumpE),       32'(e.j));
    chk("BranchE",     32'(dif.BranchE),     32'(e.b));
    chk("ALUSrcE",     32'(dif.ALUSrcE),     32'(e.as));
    chk("ResultSrcE",  32'(dif.ResultSrcE),  32'(e.rsrc));
    chk("ALUControlE", 32'(dif.ALUControlE), 32'(e.alu));
    chk("Funct3E",     32'(dif.Funct3E),     32'(e.f3));
    chk("RD1E",        dif.RD1E,             e.rd1);
    chk("RD2E",        dif.RD2E,             e.rd2);
    chk("PCE",         dif.PCE,              e.pc);
    chk("ExtImmE",     dif.ExtImmE,          e.imm);
    chk("PCPlus4E",    dif.PCPlus4E,         e.pc4);
    chk("Rs1E",        32'(dif.Rs1E),        32'(e.rs1));
    chk("Rs2E",        32'(dif.Rs2E),        32'(e.rs2));
    chk("RdE",         32'(dif.RdE),         32'(e.rd));
  endtask

  task automatic drive(input logic [31:0] ins, input logic rw, input logic [4:0] wrd,
                       input logic [31:0] res, input logic fl, input logic rs);
    exp_t e;
    logic [31:0] pc;
    @(negedge clk);
    pc = $urandom() & 32'hFFFF_FFFC;
    dif.InstrD    = ins;
    dif.PCD       = pc;
    dif.PCPlus4D  = pc + 32'd4;
    dif.RegWriteW = rw;
    dif.RdW       = wrd;
    dif.ResultW   = res;
    dif.FlushE    = fl;
    rst_n         = !rs;
    #1;
    chk("Rs1D", 32'(dif.Rs1D), 32'(ins[19:15]));
    chk("Rs2D", 32'(dif.Rs2D), 32'(ins[24:20]));
    if (rs || fl) e = '{default: '0};
    else e = model(ins, pc, rw, wrd, res);
    if (rs) begin
      for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    end else if (rw && wrd != 0) begin
      mrf[wrd] = res;
    end
    @(posedge clk);
    #1;
    compare_all(e);
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  wrd;
    int          k;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
    dif.InstrD = '0; dif.PCD = '0; dif.PCPlus4D = '0; dif.RegWriteW = 1'b0;
    dif.RdW = '0; dif.ResultW = '0; dif.FlushE = 1'b0;

    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    drive(32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    chk("rst_RegWriteE", 32'(dif.RegWriteE), 32'h0);

    // addi x1,x0,5
    drive(32'h0050_0093, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("addi_RegWriteE", 32'(dif.RegWriteE), 32'h1);
    chk("addi_ALUSrcE", 32'(dif.ALUSrcE), 32'h1);
    chk("addi_ALUControlE", 32'(dif.ALUControlE), 32'h0);
    chk("addi_ExtImmE", dif.ExtImmE, 32'h5);
    chk("addi_RdE", 32'(dif.RdE), 32'h1);

    // x3 = DEADBEEF, then sub x2,x3,x3
    drive(32'h0, 1'b1, 5'd3, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drive(32'h4031_8133, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("sub_RD1E", dif.RD1E, 32'hDEAD_BEEF);
    chk("sub_RD2E", dif.RD2E, 32'hDEAD_BEEF);
    chk("sub_ALUControlE", 32'(dif.ALUControlE), 32'h1);

    // x5 = 11111111, then add x6,x5,x0 while x5 <= 12345678 in the same cycle
    drive(32'h0, 1'b1, 5'd5, 32'h1111_1111, 1'b0, 1'b0);
    drive(32'h0002_8333, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_RD1E", dif.RD1E, 32'h1234_5678);
`else
    chk("nobypass_RD1E", dif.RD1E, 32'h1111_1111);
`endif

    // beq with offset -4, flushed then not
    drive(32'hFE00_0EE3, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    chk("flush_ExtImmE", dif.ExtImmE, 32'h0);
    chk("flush_BranchE", 32'(dif.BranchE), 32'h0);
    drive(32'hFE00_0EE3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("beq_BranchE", 32'(dif.BranchE), 32'h1);
    chk("beq_ExtImmE", dif.ExtImmE, 32'hFFFF_FFFC);

    // x0 write ignored; then reset wipes x3
    drive(32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    drive(32'h0000_00B3, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("x0_RD1E", dif.RD1E, 32'h0);
    drive(32'h4031_8133, 1'b1, 5'd7, 32'h5555_5555, 1'b1, 1'b1);
    chk("rst_PCE", dif.PCE, 32'h0);
    drive(32'h4031_8133, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    chk("rst_x3_RD1E", dif.RD1E, 32'h0);

    for (int n = 0; n < 400; n++) begin
      ins = $urandom();
      k = $urandom_range(0, 10);
      if (k < 9) ins[6:0] = op_t[k];
      wrd = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) wrd = ins[19:15];
      drive(ins, 1'($urandom_range(0, 1)), wrd, $urandom(),
            $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
